core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Control block that loads the 32-entry program memory over a valid/ready stream, then paces the 5-stage core. It issues one pipeline-advance strobe (step) every STEP_CYCLES cycles and owns the PC. It redirects the PC on branch resolution with a flush pulse, drains the pipeline after the last instruction, and reports done/error. It replaces the free-running delay counter and the simulation-only memory preload in front of the core.

Parameters:
MEM_DEPTH, 32, program memory words (load_len ceiling)
STEP_CYCLES, 5, clock cycles per pipeline advance (>=1)
DRAIN_STEPS, 4, steps issued after last instruction to empty the pipeline

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin load; sampled in IDLE/DONE only
load_len  in  6  number of words to load; legal 1..MEM_DEPTH; sampled with start
load_valid  in  1  stream word valid
load_data  in  32  stream word
load_ready  out  1  sequencer accepts word
pmem_we  out  1  program memory write enable (registered)
pmem_waddr  out  5  program memory word address
pmem_wdata  out  32  program memory write data
step  out  1  one-cycle pipeline advance strobe; fetch uses pc in same cycle
pc  out  8  byte PC, always word aligned
branch_taken  in  1  branch resolved taken (from execute)
branch_target  in  8  byte target address
flush  out  1  one-cycle pulse: squash fetch/decode stages
halt_req  in  1  stop execution
running  out  1  high in RUN or DRAIN
done  out  1  high in DONE
error  out  1  sticky error; cleared by rst or legal start

Behaviour:
- Reset (async, immediate on rst high): state IDLE; all outputs 0; internal wcnt, pace counter and drain counter 0; latched length 0.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE/DONE: start with load_len 1..32 -> LOAD next cycle; latch len; wcnt=0; error cleared; done cleared. Start with load_len 0 or >32 -> error=1, state unchanged. Start ignored in LOAD/RUN/DRAIN.
- LOAD: load_ready=1 (registered, high from the first LOAD cycle). A transfer occurs when load_valid && load_ready.
  - One cycle after each transfer: pmem_we=1, pmem_waddr=wcnt, pmem_wdata=load_data. Otherwise pmem_we=0.
  - The transfer with wcnt==len-1 -> RUN next cycle; load_ready=0 from that cycle; pc=0; pace=0.
  - load_valid low stalls indefinitely with no timeout. load_valid outside LOAD is ignored.
- RUN: pace counts 0..STEP_CYCLES-1.
  - At pace==STEP_CYCLES-1: step=1 for that cycle; pace wraps to 0.
  - pc <= pc+4, except when pc==4*(len-1): pc holds, drain counter=0, go to DRAIN.
  - First step occurs STEP_CYCLES cycles after RUN entry, with pc=0.
- DRAIN: same pacing. Each step increments the drain counter. After DRAIN_STEPS steps -> DONE. pc held.
- Branch (RUN or DRAIN, branch_taken=1):
  - In range (branch_target[7:2] < len): pc <= {branch_target[7:2],2'b00}; pace=0; flush=1 next cycle only; no step in the branch cycle (branch beats step); state -> RUN.
  - Out of range: error=1 -> DONE.
- halt_req in RUN/DRAIN: DONE next cycle; no step in that cycle.
- Priority in one cycle: halt_req > branch_taken > step.
- DONE: done=1, running=0, step=0, pc holds last value.
- Width rules: pc arithmetic is 8-bit. Overflow is impossible because pc never exceeds 4*(len-1) <= 124. branch_target[1:0] is ignored.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. Memory contents are not the sequencer's concern.

Test Plan:
- Load 3 words (0xA0,0xA1,0xA2) with continuous valid and load_len=3 -> pmem_we pulses at addr 0,1,2 one cycle after each handshake; load_ready low the cycle after the third handshake; running=1.
- RUN with STEP_CYCLES=5, len=3 -> step on cycles 5,10,15 after RUN entry with pc=0,4,8. Then 4 drain steps at pc=8 (cycles 20..35); done=1 one cycle after the 4th drain step.
- branch_taken with branch_target=0x05 during pace=2 at pc=8, len=8 -> pc=0x04, flush pulse next cycle, no step that cycle, next step exactly 5 cycles later.
- Simultaneous halt_req, branch_taken and step cycle -> no step, no flush, done=1 next cycle, pc unchanged.
- start with load_len=0, then with load_len=33 -> error=1, load_ready stays 0. Then start with load_len=1 -> error cleared, LOAD entered.
- rst asserted mid-LOAD after 2 of 5 words (between clock edges) -> all outputs 0 immediately. After release, a new start with load_len=5 restarts writes at addr 0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer
// Loads the program memory from a valid/ready word stream, then paces the
// 5-stage core with one step strobe every STEP_CYCLES cycles. Owns the PC,
// redirects it on taken branches (with a one-cycle flush), drains the pipeline
// after the last instruction and reports done/error.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   start, load_len           begin a load of load_len words (IDLE/DONE only)
//   load_valid/load_data/load_ready   program word stream handshake
//   pmem_we/pmem_waddr/pmem_wdata     registered program memory write port
//   step, pc                  pipeline advance strobe and byte PC for fetch
//   branch_taken/branch_target        branch redirect from execute
//   flush                     one-cycle squash of fetch/decode
//   halt_req                  stop execution
//   running, done, error      status (error is sticky)
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_LOAD  | accepting program words from the stream
// S_RUN   | issuing steps, advancing pc
// S_DRAIN | last instruction fetched, stepping the pipeline empty
// S_DONE  | finished (normal, halt or bad branch); pc held
module core_sequencer #(
  parameter int MEM_DEPTH   = 32,
  parameter int STEP_CYCLES = 5,
  parameter int DRAIN_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  load_len,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        pmem_we,
  output logic [4:0]  pmem_waddr,
  output logic [31:0] pmem_wdata,
  output logic        step,
  output logic [7:0]  pc,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        flush,
  input  logic        halt_req,
  output logic        running,
  output logic        done,
  output logic        error
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DW = (DRAIN_STEPS > 1) ? $clog2(DRAIN_STEPS) : 1;
  localparam logic [PW-1:0] PACE_LAST  = PW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_STEPS - 1);
  localparam logic [5:0]    MAX_LEN    = 6'(MEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [5:0]      len;
  logic [5:0]      wcnt;
  logic [PW-1:0]   pace;
  logic [DW-1:0]   dcnt;

  logic idle_like, active, start_ok, xfer, last_word, pc_at_last, br_ok, pace_tc;
  logic unused_tgt_lsbs;

  // Byte-offset bits of the target are meaningless for word-aligned fetch.
  assign unused_tgt_lsbs = ^branch_target[1:0];

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign active     = (state == S_RUN) || (state == S_DRAIN);
  assign start_ok   = (load_len != 6'd0) && (load_len <= MAX_LEN);
  assign xfer       = (state == S_LOAD) && load_valid && load_ready;
  assign last_word  = (wcnt == len - 6'd1);
  assign pc_at_last = (pc == {len - 6'd1, 2'b00});
  assign br_ok      = (branch_target[7:2] < len);
  assign pace_tc    = (pace == PACE_LAST);

  // halt and branch both suppress the step of their cycle.
  assign step    = active && !halt_req && !branch_taken && pace_tc;
  assign running = active;
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start && start_ok) state_nxt = S_LOAD;
      S_LOAD:         if (xfer && last_word) state_nxt = S_RUN;
      S_RUN, S_DRAIN: begin
        if (halt_req)            state_nxt = S_DONE;
        else if (branch_taken)   state_nxt = br_ok ? S_RUN : S_DONE;
        else if (step) begin
          if (state == S_RUN && pc_at_last)            state_nxt = S_DRAIN;
          else if (state == S_DRAIN && dcnt == DRAIN_LAST) state_nxt = S_DONE;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      wcnt       <= '0;
      pace       <= '0;
      dcnt       <= '0;
      pc         <= '0;
      load_ready <= 1'b0;
      pmem_we    <= 1'b0;
      pmem_waddr <= '0;
      pmem_wdata <= '0;
      flush      <= 1'b0;
      error      <= 1'b0;
    end else begin
      pmem_we <= xfer;
      flush   <= active && !halt_req && branch_taken && br_ok;

      if (idle_like && start) begin
        if (start_ok) begin
          len        <= load_len;
          wcnt       <= '0;
          error      <= 1'b0;
          load_ready <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end

      if (xfer) begin
        pmem_waddr <= wcnt[4:0];
        pmem_wdata <= load_data;
        wcnt       <= wcnt + 6'd1;
        if (last_word) begin
          load_ready <= 1'b0;
          pc         <= '0;
          pace       <= '0;
        end
      end

      if (active && !halt_req) begin
        if (branch_taken) begin
          if (br_ok) begin
            pc   <= {branch_target[7:2], 2'b00};
            pace <= '0;
          end else begin
            error <= 1'b1;
          end
        end else begin
          pace <= pace_tc ? '0 : pace + 1'b1;
          if (step) begin
            if (state == S_RUN) begin
              if (pc_at_last) dcnt <= '0;
              else            pc   <= pc + 8'd4;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (MEM_DEPTH=32, STEP_CYCLES=5, DRAIN_STEPS=4).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// in the same window, away from the edge.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        pmem_we;
  logic [4:0]  pmem_waddr;
  logic [31:0] pmem_wdata;
  logic        step;
  logic [7:0]  pc;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        flush;
  logic        halt_req;
  logic        running;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  core_sequencer #(.MEM_DEPTH(32), .STEP_CYCLES(5), .DRAIN_STEPS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .pmem_we(pmem_we), .pmem_waddr(pmem_waddr), .pmem_wdata(pmem_wdata),
    .step(step), .pc(pc), .branch_taken(branch_taken),
    .branch_target(branch_target), .flush(flush), .halt_req(halt_req),
    .running(running), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [5:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
    load_len = 6'd0;
  endtask

  // Feed n words; total is the programmed length, so ready drops after word total-1.
  task automatic load_words(input int n, input int total, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 32'(i);
      tick();
      chk("ld_we",    {31'b0, pmem_we},    32'd1);
      chk("ld_waddr", {27'b0, pmem_waddr}, 32'(i));
      chk("ld_wdata", pmem_wdata,          base + 32'(i));
      chk("ld_ready", {31'b0, load_ready}, (i < total - 1) ? 32'd1 : 32'd0);
      chk("ld_run",   {31'b0, running},    (i < total - 1) ? 32'd0 : 32'd1);
    end
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
    branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;

    #3;
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_we",    {31'b0, pmem_we},    32'd0);
    chk("rst_pc",    {24'b0, pc},         32'd0);
    chk("rst_step",  {31'b0, step},       32'd0);
    chk("rst_done",  {31'b0, done},       32'd0);
    chk("rst_err",   {31'b0, error},      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Illegal lengths set error and stay idle; a legal start clears it.
    do_start(6'd0);
    chk("len0_err",   {31'b0, error},      32'd1);
    chk("len0_ready", {31'b0, load_ready}, 32'd0);
    do_start(6'd33);
    chk("len33_err",   {31'b0, error},      32'd1);
    chk("len33_ready", {31'b0, load_ready}, 32'd0);
    chk("len33_run",   {31'b0, running},    32'd0);
    do_start(6'd1);
    chk("len1_err",   {31'b0, error},      32'd0);
    chk("len1_ready", {31'b0, load_ready}, 32'd1);
    load_words(1, 1, 32'h55);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_done", {31'b0, done},    32'd1);
    chk("halt_run",  {31'b0, running}, 32'd0);

    // Three-word program, full run and drain.
    do_start(6'd3);
    chk("l3_done",  {31'b0, done},       32'd0);
    chk("l3_ready", {31'b0, load_ready}, 32'd1);
    load_words(3, 3, 32'hA0);
    for (int n = 1; n <= 36; n++) begin
      chk("run_step", {31'b0, step}, ((n % 5 == 0) && n <= 35) ? 32'd1 : 32'd0);
      chk("run_pc",   {24'b0, pc},   (n <= 5) ? 32'd0 : (n <= 10) ? 32'd4 : 32'd8);
      chk("run_done", {31'b0, done}, (n == 36) ? 32'd1 : 32'd0);
      chk("run_running", {31'b0, running}, (n < 36) ? 32'd1 : 32'd0);
      if (n == 2) chk("run_we_idle", {31'b0, pmem_we}, 32'd0);
      if (n < 36) tick();
    end

    // Eight-word program; branch at pc=8, pace=2 (RUN cycle 13).
    do_start(6'd8);
    load_words(8, 8, 32'h10);
    for (int n = 1; n < 13; n++) tick();
    chk("pre_br_pc",   {24'b0, pc},   32'd8);
    chk("pre_br_step", {31'b0, step}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 8'h05;
    #1;
    chk("br_nostep", {31'b0, step}, 32'd0);
    tick();
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    chk("br_pc",    {24'b0, pc},    32'd4);
    chk("br_flush", {31'b0, flush}, 32'd1);
    chk("br_run",   {31'b0, running}, 32'd1);
    for (int n = 15; n <= 18; n++) begin
      tick();
      chk("post_br_flush", {31'b0, flush}, 32'd0);
      chk("post_br_step",  {31'b0, step},  (n == 18) ? 32'd1 : 32'd0);
      chk("post_br_pc",    {24'b0, pc},    32'd4);
    end
    for (int n = 19; n <= 23; n++) tick();
    chk("c23_pc",   {24'b0, pc},   32'd8);
    chk("c23_step", {31'b0, step}, 32'd1);

    // halt + branch + step cycle together: halt wins.
    halt_req      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h00;
    #1;
    chk("hbs_nostep", {31'b0, step}, 32'd0);
    tick();
    halt_req     = 1'b0;
    branch_taken = 1'b0;
    chk("hbs_done",  {31'b0, done},    32'd1);
    chk("hbs_flush", {31'b0, flush},   32'd0);
    chk("hbs_pc",    {24'b0, pc},      32'd8);
    chk("hbs_run",   {31'b0, running}, 32'd0);

    // Reset between edges in the middle of a 5-word load.
    do_start(6'd5);
    chk("l5_ready", {31'b0, load_ready}, 32'd1);
    load_words(2, 5, 32'h200);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, load_ready}, 32'd0);
    chk("mid_rst_we",    {31'b0, pmem_we},    32'd0);
    chk("mid_rst_waddr", {27'b0, pmem_waddr}, 32'd0);
    chk("mid_rst_wdata", pmem_wdata,          32'd0);
    chk("mid_rst_pc",    {24'b0, pc},         32'd0);
    chk("mid_rst_run",   {31'b0, running},    32'd0);
    chk("mid_rst_done",  {31'b0, done},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(6'd5);
    load_words(5, 5, 32'h300);
    chk("reload_pc", {24'b0, pc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
